// File: rtl/hs_ram_bridge_if.sv
// hs_ram_bridge_if: signal bundle for the controller, CPU and work-RAM sides of hs_ram_bridge
interface hs_ram_bridge_if #(parameter int AW = 11, parameter int DW = 8);
    logic          hs_access, hs_write, hs_ready, hs_data_valid;
    logic [AW-1:0] hs_address, cpu_addr, ram_addr;
    logic [DW-1:0] hs_data_in, hs_data_out, cpu_din, cpu_dout, ram_din, ram_dout;
    logic          cpu_cs, cpu_we, cpu_hold, cpu_idle, ram_we, timeout_flag;
    modport master (
        output hs_access, hs_address, hs_data_in, hs_write, cpu_addr, cpu_din, cpu_cs, cpu_we, cpu_idle, ram_dout,
        input  hs_ready, hs_data_out, hs_data_valid, cpu_dout, cpu_hold, ram_addr, ram_din, ram_we, timeout_flag
    );
    modport slave (
        input  hs_access, hs_address, hs_data_in, hs_write, cpu_addr, cpu_din, cpu_cs, cpu_we, cpu_idle, ram_dout,
        output hs_ready, hs_data_out, hs_data_valid, cpu_dout, cpu_hold, ram_addr, ram_din, ram_we, timeout_flag
    );
endinterface

// File: rtl/hs_ram_bridge.sv
// hs_ram_bridge: arbitrates the single-port work RAM between the game CPU and the high-score controller
module hs_ram_bridge #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023
) (
    input logic            clk_sys,
    input logic            reset_n,
    hs_ram_bridge_if.slave bus
);
    typedef enum logic [1:0] {CPU, REQ, GRANT, RELEASE} state_t;
    state_t        state, state_nx;
    logic [3:0]    idle_cnt, idle_nx;
    logic [9:0]    to_cnt, to_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] din_nx, cpu_dout_q;
    logic          we_nx, force_grant, cpu_path, rd_p0, rd_p1;
    always_comb begin
        state_nx    = state;
        idle_nx     = 4'd0;
        to_nx       = 10'd0;
        force_grant = 1'b0;
        case (state)
            CPU:   state_nx = bus.hs_access ? REQ : CPU;
            REQ: begin
                idle_nx = bus.cpu_idle ? idle_cnt + 4'd1 : 4'd0;
                to_nx   = to_cnt + 10'd1;
                if (!bus.hs_access) begin
                    state_nx = CPU;
                    idle_nx  = 4'd0;
                    to_nx    = 10'd0;
                end else if (idle_nx == 4'(SETTLE)) begin
                    state_nx = GRANT;
                end else if (to_nx == 10'(TIMEOUT)) begin
                    state_nx    = GRANT;
                    force_grant = 1'b1;
                end
            end
            GRANT: state_nx = bus.hs_access ? GRANT : RELEASE;
            default: state_nx = CPU;
        endcase
        cpu_path = state == CPU || state == REQ;
        addr_nx  = state == GRANT ? bus.hs_address : bus.cpu_addr;
        din_nx   = state == GRANT ? bus.hs_data_in : bus.cpu_din;
        we_nx    = state == GRANT ? bus.hs_write : cpu_path & bus.cpu_cs & bus.cpu_we;
    end
    assign bus.hs_ready = state == GRANT;
    assign bus.cpu_hold = state != CPU;
    assign bus.cpu_dout = cpu_path ? bus.ram_dout : cpu_dout_q;
    // read pipeline: address register, RAM latency, then output register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state             <= CPU;
            idle_cnt          <= 4'd0;
            to_cnt            <= 10'd0;
            bus.timeout_flag  <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_din       <= '0;
            bus.ram_we        <= 1'b0;
            rd_p0             <= 1'b0;
            rd_p1             <= 1'b0;
            bus.hs_data_valid <= 1'b0;
            bus.hs_data_out   <= '0;
            cpu_dout_q        <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
            to_cnt   <= to_nx;
            if (force_grant) bus.timeout_flag <= 1'b1;
            bus.ram_we <= we_nx;
            if (state != RELEASE) begin
                bus.ram_addr <= addr_nx;
                bus.ram_din  <= din_nx;
            end
            rd_p0             <= state == GRANT && !bus.hs_write;
            rd_p1             <= rd_p0;
            bus.hs_data_valid <= rd_p1;
            if (rd_p1) bus.hs_data_out <= bus.ram_dout;
            if (cpu_path) cpu_dout_q <= bus.ram_dout;
        end
    end
endmodule

// File: tb/tb_hs_ram_bridge.sv
// tb_hs_ram_bridge: directed self-checking bench for hs_ram_bridge
module tb_hs_ram_bridge;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int errs = 0;
    int checks = 0;
    logic [7:0] mem [2048];
    localparam logic [7:0] VALS [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    hs_ram_bridge_if #(.AW(11), .DW(8)) b();
    hs_ram_bridge #(.AW(11), .DW(8), .SETTLE(2), .TIMEOUT(1023)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(b)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (b.ram_we) mem[b.ram_addr] <= b.ram_din;
        b.ram_dout <= mem[b.ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (b.hs_ready !== 1'b0) begin errs++; $display("FAIL reset_hs_ready got=%0h want=0", b.hs_ready); end
        checks++; if (b.cpu_hold !== 1'b0) begin errs++; $display("FAIL reset_cpu_hold got=%0h want=0", b.cpu_hold); end
        checks++; if (b.ram_we !== 1'b0) begin errs++; $display("FAIL reset_ram_we got=%0h want=0", b.ram_we); end
        checks++; if (b.timeout_flag !== 1'b0) begin errs++; $display("FAIL reset_timeout got=%0h want=0", b.timeout_flag); end
        checks++; if (b.hs_data_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0h want=0", b.hs_data_valid); end
        checks++; if (b.ram_addr !== 11'h000 || b.hs_data_out !== 8'h00) begin errs++; $display("FAIL reset_regs addr=%0h dout=%0h want=0/0", b.ram_addr, b.hs_data_out); end
        #9 reset_n = 1'b1;
    endtask

    task automatic test_cpu_preload();
        for (int i = 0; i < 4; i++) begin
            b.cpu_addr = 11'h7A0 + 11'(i);
            b.cpu_din = VALS[i];
            b.cpu_cs = 1'b1;
            b.cpu_we = 1'b1;
            tick();
        end
        checks++; if (b.ram_we !== 1'b1 || b.ram_addr !== 11'h7A3 || b.ram_din !== 8'h44) begin errs++; $display("FAIL cpu_fwd we=%0h addr=%0h din=%0h want=1/7a3/44", b.ram_we, b.ram_addr, b.ram_din); end
        b.cpu_we = 1'b0;
        b.cpu_addr = 11'h7A2;
        tick();
        tick();
        checks++; if (b.cpu_dout !== 8'h33) begin errs++; $display("FAIL cpu_read got=%0h want=33", b.cpu_dout); end
        b.cpu_cs = 1'b0;
    endtask

    task automatic test_idle_write();
        b.hs_write = 1'b1;
        b.hs_address = 11'h300;
        b.hs_data_in = 8'hEE;
        tick();
        tick();
        tick();
        checks++; if (b.ram_we !== 1'b0 || b.hs_data_valid !== 1'b0) begin errs++; $display("FAIL idle_write we=%0h valid=%0h want=0/0", b.ram_we, b.hs_data_valid); end
        b.hs_write = 1'b0;
    endtask

    task automatic test_handshake();
        b.cpu_idle = 1'b0;
        b.hs_access = 1'b1;
        tick();
        checks++; if (b.cpu_hold !== 1'b1 || b.hs_ready !== 1'b0) begin errs++; $display("FAIL hs_hold hold=%0h ready=%0h want=1/0", b.cpu_hold, b.hs_ready); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (b.hs_ready !== 1'b0) begin errs++; $display("FAIL hs_no_idle ready=%0h want=0", b.hs_ready); end
        b.cpu_idle = 1'b1;
        tick();
        checks++; if (b.hs_ready !== 1'b0) begin errs++; $display("FAIL hs_settle1 ready=%0h want=0", b.hs_ready); end
        b.hs_address = 11'h7A0;
        tick();
        checks++; if (b.hs_ready !== 1'b1) begin errs++; $display("FAIL hs_settle2 ready=%0h want=1", b.hs_ready); end
        checks++; if (b.timeout_flag !== 1'b0) begin errs++; $display("FAIL hs_timeout_flag got=%0h want=0", b.timeout_flag); end
    endtask

    task automatic test_reads();
        for (int i = 0; i < 6; i++) begin
            b.hs_address = 11'h7A0 + 11'(i < 3 ? i : 3);
            tick();
            checks++;
            if (i < 2) begin
                if (b.hs_data_valid !== 1'b0) begin errs++; $display("FAIL rd_early%0d valid=%0h want=0", i, b.hs_data_valid); end
            end else if (b.hs_data_valid !== 1'b1 || b.hs_data_out !== VALS[i-2]) begin
                errs++; $display("FAIL rd_data%0d valid=%0h data=%0h want=1/%0h", i - 2, b.hs_data_valid, b.hs_data_out, VALS[i-2]);
            end
        end
    endtask

    task automatic test_write_mask();
        b.hs_address = 11'h123;
        b.hs_data_in = 8'h5A;
        b.hs_write = 1'b1;
        b.hs_access = 1'b0;
        b.cpu_addr = 11'h123;
        b.cpu_din = 8'hFF;
        b.cpu_cs = 1'b1;
        b.cpu_we = 1'b1;
        tick();
        checks++; if (b.ram_we !== 1'b1 || b.ram_din !== 8'h5A || b.ram_addr !== 11'h123) begin errs++; $display("FAIL wr_last we=%0h din=%0h addr=%0h want=1/5a/123", b.ram_we, b.ram_din, b.ram_addr); end
        checks++; if (b.hs_ready !== 1'b0 || b.cpu_hold !== 1'b1) begin errs++; $display("FAIL rel_state ready=%0h hold=%0h want=0/1", b.hs_ready, b.cpu_hold); end
        b.hs_write = 1'b0;
        b.cpu_we = 1'b0;
        tick();
        checks++; if (b.cpu_hold !== 1'b0 || b.ram_we !== 1'b0) begin errs++; $display("FAIL rel_exit hold=%0h we=%0h want=0/0", b.cpu_hold, b.ram_we); end
        tick();
        tick();
        checks++; if (b.cpu_dout !== 8'h5A) begin errs++; $display("FAIL mask_read got=%0h want=5a", b.cpu_dout); end
        b.cpu_cs = 1'b0;
    endtask

    task automatic test_abort();
        b.cpu_idle = 1'b0;
        b.cpu_cs = 1'b1;
        b.cpu_we = 1'b1;
        b.hs_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b.cpu_addr = 11'h050 + 11'(i);
            b.cpu_din = 8'hA0 + 8'(i);
            tick();
            checks++; if (b.ram_we !== 1'b1 || b.hs_ready !== 1'b0 || b.cpu_hold !== 1'b1) begin errs++; $display("FAIL abort_req%0d we=%0h ready=%0h hold=%0h want=1/0/1", i, b.ram_we, b.hs_ready, b.cpu_hold); end
        end
        b.hs_access = 1'b0;
        b.cpu_addr = 11'h053;
        b.cpu_din = 8'hA3;
        tick();
        checks++; if (b.cpu_hold !== 1'b0 || b.ram_we !== 1'b1 || b.ram_addr !== 11'h053) begin errs++; $display("FAIL abort_drop hold=%0h we=%0h addr=%0h want=0/1/53", b.cpu_hold, b.ram_we, b.ram_addr); end
        b.cpu_we = 1'b0;
        b.cpu_addr = 11'h052;
        tick();
        tick();
        checks++; if (b.cpu_dout !== 8'hA2) begin errs++; $display("FAIL abort_read got=%0h want=a2", b.cpu_dout); end
        b.cpu_cs = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        b.cpu_idle = 1'b0;
        b.hs_access = 1'b1;
        tick();
        while (b.hs_ready !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        checks++; if (n != 1023) begin errs++; $display("FAIL to_cycles got=%0d want=1023", n); end
        checks++; if (b.timeout_flag !== 1'b1) begin errs++; $display("FAIL to_flag got=%0h want=1", b.timeout_flag); end
        b.hs_access = 1'b0;
        tick();
        tick();
        checks++; if (b.timeout_flag !== 1'b1 || b.cpu_hold !== 1'b0) begin errs++; $display("FAIL to_sticky flag=%0h hold=%0h want=1/0", b.timeout_flag, b.cpu_hold); end
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        #1;
        checks++; if (b.timeout_flag !== 1'b0) begin errs++; $display("FAIL to_clear got=%0h want=0", b.timeout_flag); end
    endtask

    task automatic test_async_reset();
        b.cpu_idle = 1'b1;
        b.hs_access = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (b.hs_ready !== 1'b1) begin errs++; $display("FAIL ar_grant ready=%0h want=1", b.hs_ready); end
        b.hs_address = 11'h200;
        b.hs_data_in = 8'h77;
        b.hs_write = 1'b1;
        tick();
        checks++; if (b.ram_we !== 1'b1) begin errs++; $display("FAIL ar_we_pre got=%0h want=1", b.ram_we); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (b.ram_we !== 1'b0 || b.hs_ready !== 1'b0 || b.cpu_hold !== 1'b0) begin errs++; $display("FAIL ar_async we=%0h ready=%0h hold=%0h want=0/0/0", b.ram_we, b.hs_ready, b.cpu_hold); end
        b.hs_write = 1'b0;
        b.cpu_idle = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++; if (b.cpu_hold !== 1'b1 || b.hs_ready !== 1'b0) begin errs++; $display("FAIL ar_restart hold=%0h ready=%0h want=1/0", b.cpu_hold, b.hs_ready); end
        b.hs_access = 1'b0;
    endtask

    initial begin
        b.hs_access = 1'b0;
        b.hs_address = '0;
        b.hs_data_in = '0;
        b.hs_write = 1'b0;
        b.cpu_addr = '0;
        b.cpu_din = '0;
        b.cpu_cs = 1'b0;
        b.cpu_we = 1'b0;
        b.cpu_idle = 1'b0;
        test_reset();
        tick();
        test_cpu_preload();
        test_idle_write();
        test_handshake();
        test_reads();
        test_write_mask();
        test_abort();
        test_timeout();
        test_async_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
